// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: instruction field positions, decoded control
// bundle and the default reset program counter.
package hack_pkg;

    localparam logic [14:0] RESET_PC_DEFAULT = 15'h0000;

    localparam int OPCODE_BIT = 15;
    localparam int A_BIT      = 12;
    localparam int COMP_HI    = 11;
    localparam int COMP_LO    = 6;
    localparam int DEST_HI    = 5;
    localparam int DEST_LO    = 3;
    localparam int JUMP_HI    = 2;
    localparam int JUMP_LO    = 0;

    typedef struct packed {
        logic       is_c;
        logic       a_sel;
        logic [5:0] comp;
        logic       dest_a;
        logic       dest_d;
        logic       dest_m;
        logic       jlt;
        logic       jeq;
        logic       jgt;
    } hack_ctrl_t;

endpackage

// File: rtl/hack_cpu_alu.sv
// 16-bit Hack ALU: optional zero/negate on each operand, add or AND,
// optional output negate, plus zero and negative flags.
module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic        zr,
    output logic        ng,
    output logic [15:0] out
);

    logic [15:0] w_x_z;
    logic [15:0] w_x_n;
    logic [15:0] w_y_z;
    logic [15:0] w_y_n;
    logic [15:0] w_fn;

    assign w_x_z = zx ? 16'h0000 : x;
    assign w_x_n = nx ? ~w_x_z : w_x_z;
    assign w_y_z = zy ? 16'h0000 : y;
    assign w_y_n = ny ? ~w_y_z : w_y_z;
    assign w_fn  = f ? (w_x_n + w_y_n) : (w_x_n & w_y_n);
    assign out   = no ? ~w_fn : w_fn;
    assign zr    = (out == 16'h0000);
    assign ng    = out[15];

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: A/D/PC registers, one instruction per valid cycle, with the
// memory write port and ALU result driven combinationally.
module hack_cpu
    import hack_pkg::*;
#(
    parameter logic [14:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instruction,
    input  logic        instr_valid,
    input  logic [15:0] in_m,
    output logic [15:0] out_m,
    output logic        write_m,
    output logic [14:0] address_m,
    output logic [14:0] pc
);

    logic [15:0] r_a;
    logic [15:0] r_d;
    logic [14:0] r_pc;
    logic [15:0] w_a_nxt;
    logic [15:0] w_d_nxt;
    logic [14:0] w_pc_nxt;
    logic [14:0] w_pc_inc;
    logic [15:0] w_y;
    logic [15:0] w_alu_out;
    logic        w_zr;
    logic        w_ng;
    logic        w_jump;
    hack_ctrl_t  w_ctrl;

    assign w_ctrl = '{
        is_c:   instruction[OPCODE_BIT],
        a_sel:  instruction[A_BIT],
        comp:   instruction[COMP_HI:COMP_LO],
        dest_a: instruction[DEST_HI],
        dest_d: instruction[DEST_HI-1],
        dest_m: instruction[DEST_LO],
        jlt:    instruction[JUMP_HI],
        jeq:    instruction[JUMP_HI-1],
        jgt:    instruction[JUMP_LO]
    };

    assign w_y = w_ctrl.a_sel ? in_m : r_a;

    alu u_alu (
        .x   (r_d),
        .y   (w_y),
        .zx  (w_ctrl.comp[5]),
        .nx  (w_ctrl.comp[4]),
        .zy  (w_ctrl.comp[3]),
        .ny  (w_ctrl.comp[2]),
        .f   (w_ctrl.comp[1]),
        .no  (w_ctrl.comp[0]),
        .zr  (w_zr),
        .ng  (w_ng),
        .out (w_alu_out)
    );

    assign w_jump    = (w_ctrl.jlt & w_ng) | (w_ctrl.jeq & w_zr) |
                       (w_ctrl.jgt & ~w_ng & ~w_zr);
    assign w_pc_inc  = r_pc + 15'd1;

    // rst_n gating keeps the strobe quiet while the core is held in reset
    assign write_m   = rst_n & instr_valid & w_ctrl.is_c & w_ctrl.dest_m;
    assign out_m     = w_alu_out;
    assign address_m = r_a[14:0];
    assign pc        = r_pc;

    // Next-state selection; the jump target is always the pre-update A.
    always_comb begin
        w_a_nxt  = r_a;
        w_d_nxt  = r_d;
        w_pc_nxt = r_pc;
        if (instr_valid) begin
            if (!w_ctrl.is_c) begin
                w_a_nxt  = {1'b0, instruction[14:0]};
                w_pc_nxt = w_pc_inc;
            end else begin
                if (w_ctrl.dest_a) begin
                    w_a_nxt = w_alu_out;
                end else begin
                    w_a_nxt = r_a;
                end
                if (w_ctrl.dest_d) begin
                    w_d_nxt = w_alu_out;
                end else begin
                    w_d_nxt = r_d;
                end
                w_pc_nxt = w_jump ? r_a[14:0] : w_pc_inc;
            end
        end else begin
            w_pc_nxt = r_pc;
        end
    end

    // Architectural register update with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= 16'h0000;
            r_d  <= 16'h0000;
            r_pc <= RESET_PC;
        end else begin
            r_a  <= w_a_nxt;
            r_d  <= w_d_nxt;
            r_pc <= w_pc_nxt;
        end
    end

endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: a mnemonic-level Hack model checked every
// cycle, directed instruction sequences with literal expectations, and random programs.
module tb_hack_cpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instruction = 16'h0000;
    logic        instr_valid = 1'b0;
    logic [15:0] in_m = 16'h0000;

    logic [15:0] out_m, out_m2;
    logic        write_m, write_m2;
    logic [14:0] address_m, address_m2;
    logic [14:0] pc, pc2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;
    logic [15:0] m_res;
    logic        m_taken;

    logic [5:0] comps [18] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
    };

    hack_cpu dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
        .in_m(in_m), .out_m(out_m), .write_m(write_m), .address_m(address_m), .pc(pc)
    );

    hack_cpu #(.RESET_PC(15'h7FFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .instr_valid(instr_valid),
        .in_m(in_m), .out_m(out_m2), .write_m(write_m2), .address_m(address_m2), .pc(pc2)
    );

    always #5 clk = ~clk;

    // Hack computation table by mnemonic: x is D, y is A or M.
    function automatic logic [15:0] ref_alu(input logic [15:0] ins, input logic [15:0] a,
                                            input logic [15:0] d, input logic [15:0] m);
        logic [15:0] y;
        y = ins[12] ? m : a;
        case (ins[11:6])
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return d;
            6'b110000: return y;
            6'b001101: return ~d;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - d;
            6'b110011: return 16'd0 - y;
            6'b011111: return d + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return d - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return d + y;
            6'b010011: return d - y;
            6'b000111: return y - d;
            6'b000000: return d & y;
            6'b010101: return d | y;
            default:   return 16'h0000;
        endcase
    endfunction

    assign m_res   = ref_alu(instruction, m_a, m_d, in_m);
    assign m_taken = (instruction[2] && ($signed(m_res) < 0)) ||
                     (instruction[1] && (m_res == 16'd0)) ||
                     (instruction[0] && ($signed(m_res) > 0));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a  <= 16'h0000;
            m_d  <= 16'h0000;
            m_pc <= 15'h0000;
        end else if (instr_valid) begin
            if (!instruction[15]) begin
                m_a  <= {1'b0, instruction[14:0]};
                m_pc <= m_pc + 15'd1;
            end else begin
                if (instruction[5]) m_a <= m_res;
                if (instruction[4]) m_d <= m_res;
                m_pc <= m_taken ? m_a[14:0] : m_pc + 15'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_pc", {17'd0, pc}, {17'd0, m_pc});
            check("cyc_address_m", {17'd0, address_m}, {17'd0, m_a[14:0]});
            check("cyc_write_m", {31'd0, write_m},
                  {31'd0, rst_n & instr_valid & instruction[15] & instruction[3]});
            if (instruction[15]) check("cyc_out_m", {16'd0, out_m}, {16'd0, m_res});
        end
    end

    task automatic apply(input logic [15:0] ins, input logic v, input logic [15:0] m);
        instruction = ins;
        instr_valid = v;
        in_m        = m;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ins;
        tick();
        tick();
        chk_en = 1'b1;
        apply(16'hE30C, 1'b0, 16'h0000);
        check("rst_pc", {17'd0, pc}, 32'h0);
        check("rst_a", {17'd0, address_m}, 32'h0);
        check("rst_d", {16'd0, out_m}, 32'h0);
        check("rst_pc_wrap", {17'd0, pc2}, 32'h7FFF);
        apply(16'hE308, 1'b1, 16'h0000);
        check("rst_write_m", {31'd0, write_m}, 32'h0);
        tick();

        rst_n = 1'b1;
        apply(16'h0011, 1'b1, 16'h0000);
        check("first_pc", {17'd0, pc}, 32'h0);
        tick();
        check("ainst_pc", {17'd0, pc}, 32'h1);
        check("ainst_addr", {17'd0, address_m}, 32'h11);
        check("wrap_pc", {17'd0, pc2}, 32'h0);
        apply(16'hEC10, 1'b1, 16'h0000);
        tick();
        check("d_eq_a_pc", {17'd0, pc}, 32'h2);
        apply(16'hE7C8, 1'b1, 16'h0000);
        check("mdp1_out", {16'd0, out_m}, 32'd18);
        check("mdp1_wm", {31'd0, write_m}, 32'h1);
        check("mdp1_addr", {17'd0, address_m}, 32'd17);
        tick();
        check("mdp1_pc", {17'd0, pc}, 32'h3);

        apply(16'h0005, 1'b1, 16'h0000);
        tick();
        apply(16'hEA87, 1'b1, 16'h0000);
        tick();
        check("jmp_pc", {17'd0, pc}, 32'h5);
        apply(16'hEA90, 1'b1, 16'h0000);
        tick();
        apply(16'hE301, 1'b1, 16'h0000);
        check("jgt_d0_out", {16'd0, out_m}, 32'h0);
        tick();
        check("jgt_nt_pc", {17'd0, pc}, 32'h7);

        apply(16'h000A, 1'b1, 16'h0000);
        tick();
        apply(16'hFDEA, 1'b1, 16'hFFFF);
        check("sim_wm", {31'd0, write_m}, 32'h1);
        check("sim_addr", {17'd0, address_m}, 32'd10);
        check("sim_out", {16'd0, out_m}, 32'h0);
        tick();
        check("sim_pc", {17'd0, pc}, 32'd10);
        check("sim_a", {17'd0, address_m}, 32'h0);

        apply(16'hE7C8, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            check("stall_wm", {31'd0, write_m}, 32'h0);
            tick();
            check("stall_pc", {17'd0, pc}, 32'd10);
            check("stall_a", {17'd0, address_m}, 32'h0);
            check("stall_d", {16'd0, out_m}, 32'h1);
        end

        for (int i = 0; i < 400; i++) begin
            ins = 16'h0000;
            if ($urandom_range(0, 2) == 0) begin
                ins = {1'b0, 15'($urandom)};
            end else begin
                ins[15]    = 1'b1;
                ins[14:13] = 2'($urandom);
                ins[12]    = 1'($urandom);
                ins[11:6]  = comps[$urandom_range(0, 17)];
                ins[5:0]   = 6'($urandom);
            end
            apply(ins, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
            tick();
        end

        apply(16'h0100, 1'b1, 16'h0000);
        tick();
        apply(16'hE308, 1'b1, 16'h0000);
        check("pre_async_wm", {31'd0, write_m}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", {17'd0, pc}, 32'h0);
        check("async_pc_wrap", {17'd0, pc2}, 32'h7FFF);
        check("async_a", {17'd0, address_m}, 32'h0);
        check("async_wm", {31'd0, write_m}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        apply(16'h0003, 1'b1, 16'h0000);
        check("rel_pc", {17'd0, pc}, 32'h0);
        tick();
        check("rel_exec_pc", {17'd0, pc}, 32'h1);
        check("rel_exec_a", {17'd0, address_m}, 32'h3);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hack_cpu.md
HACK_CPU -- requirements
Module: hack_cpu

Interface
REQ-001 SHALL have parameter RESET_PC, default 15'h0000: the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instruction  input  16  the current Hack instruction word.
REQ-005 SHALL have port instr_valid  input  1  high when instruction is valid this cycle; low stalls the core.
REQ-006 SHALL have port in_m  input  16  data memory read value at address_m.
REQ-007 SHALL have port out_m  output  16  data memory write value (ALU result).
REQ-008 SHALL have port write_m  output  1  data memory write strobe.
REQ-009 SHALL have port address_m  output  15  data memory address, equal to A[14:0].
REQ-010 SHALL have port pc  output  15  instruction address, equal to the PC register.

Function
REQ-011 SHALL hold three registers: A (16b), D (16b), PC (15b).
REQ-012 A-instruction (bit15=0), when instr_valid=1: SHALL set A <= {1'b0, instruction[14:0]} and PC <= PC+1, with D unchanged.
REQ-013 C-instruction (bit15=1): SHALL ignore bits 14:13; bit12=a, bits 11:6 = zx,nx,zy,ny,f,no, bits 5:3 = dest A,D,M, bits 2:0 = jump lt,eq,gt.
REQ-014 SHALL drive the ALU with x=D and y=(a ? in_m : A); out_m = ALU out, combinational in every cycle.
REQ-015 SHALL drive write_m = instr_valid & bit15 & dest-M, combinational; it SHALL be 0 during reset.
REQ-016 dest-A/dest-D SHALL load the ALU result at the clock edge; M, A and D may all be written by one instruction.
REQ-017 Jump condition SHALL be (lt&ng)|(eq&zr)|(gt&~ng&~zr); when taken, PC <= old A[14:0], else PC <= PC+1.
REQ-018 Simultaneous dest-A and jump SHALL use the pre-update A as target; the M write SHALL use the pre-update A as address.
REQ-019 When instr_valid=0, A, D and PC SHALL hold and write_m SHALL be 0.
REQ-020 PC SHALL wrap from 15'h7FFF to 15'h0000 on increment.
REQ-021 Latency: one instruction per valid cycle; register effects are visible on the cycle after the edge.

Reset
REQ-022 While rst_n=0: A=0, D=0, PC=RESET_PC, applied immediately (asynchronous), including mid-instruction.
REQ-023 On deassertion, the first rising edge with instr_valid=1 SHALL execute the instruction at PC=RESET_PC.

Structure
REQ-024 Shared package hack_pkg SHALL hold field position constants (opcode bit, a bit, comp/dest/jump ranges) and the RESET_PC default.
REQ-025 SHALL instantiate the existing 16-bit Hack ALU sub-module alu (x, y, zx, nx, zy, ny, f, no -> zr, ng, out); no other sub-modules.

Verification
REQ-026 Reset: rst_n=0 for 2 cycles, then 1 -> pc=0, A=0, D=0, write_m=0.
REQ-027 Load/compute: 0x0011 (@17), 0xEC10 (D=A), 0xE7C8 (M=D+1) -> D=17; on the third instruction out_m=18, write_m=1, address_m=17; pc steps 0,1,2,3.
REQ-028 Jumps: @5 (0x0005), 0xEA87 (0;JMP) -> pc=5. With D=0, 0xE301 (D;JGT) -> not taken, pc increments.
REQ-029 Simultaneous: A=10, in_m=16'hFFFF, 0xFDEA (AM=M+1;JEQ) -> write_m=1, address_m=10, out_m=0, next A=0, pc=10.
REQ-030 Stall: hold 0xE7C8 with instr_valid=0 for 3 cycles -> pc, A and D unchanged, write_m=0 throughout.
REQ-031 Wrap/async: RESET_PC=15'h7FFF with a non-jump instruction -> pc=0; assert rst_n between edges -> pc=RESET_PC immediately.
